pingpong_sram_ctrl: RTL and testbench

Initiator for the dual-bank SRAM pair. The banks share one address bus and have independent cs/oe/we and bidirectional data. Incoming words stream into one bank (write bank). In the same cycle, the same address is read from the other bank (read bank), which holds the previous frame. Banks swap at every frame boundary, so the block is a frame-delay buffer of DEPTH words feeding the downstream binarized-layer datapath.

---
 rtl/pingpong_sram_ctrl.sv | 117 +++++++++++
 tb/tb_pingpong_sram_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_sram_ctrl.sv
// pingpong_sram_ctrl: frame-delay buffer over two SRAM banks; one bank is written
// while the other replays the previous frame at the same address.
module pingpong_sram_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  drain_done,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  cs1,
    output logic                  cs2,
    output logic                  we1,
    output logic                  we2,
    output logic                  oe1,
    output logic                  oe2,
    inout  wire  [DATA_WIDTH-1:0] data1,
    inout  wire  [DATA_WIDTH-1:0] data2
);
    typedef enum logic [1:0] {FILL, STREAM, DRAIN} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    logic                  wr_bank, rd_pend, rd_bank_q, rd_last_q, drain_all;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [1:0]            buf_last, occ;
    logic                  wp, rp;
    logic                  pop, room, conflict, wr, rd, at_last, done;
    logic [DATA_WIDTH-1:0] rd_data;

    assign pop      = out_valid && out_ready;
    assign room     = ({1'b0, occ} + {2'b0, rd_pend} - {2'b0, pop}) < 3'd2;
    // The first write of a frame lands on the bank still returning the last read.
    assign conflict = rd_pend && (rd_bank_q == wr_bank);
    assign at_last  = addr == LAST;
    assign in_ready = rst_n && (state == FILL ? 1'b1 :
                      state == STREAM ? room && !conflict && !(addr == '0 && flush) : 1'b0);
    assign wr       = in_valid && in_ready;
    assign rd       = state == STREAM ? wr : (state == DRAIN && room && !drain_all);
    assign done     = state == DRAIN && drain_all && pop && out_last;

    assign we1   = wr && !wr_bank;
    assign we2   = wr && wr_bank;
    assign cs1   = we1 || (rd && wr_bank);
    assign cs2   = we2 || (rd && !wr_bank);
    assign oe1   = rd_pend && !rd_bank_q;
    assign oe2   = rd_pend && rd_bank_q;
    assign data1 = we1 ? in_data : 'z;
    assign data2 = we2 ? in_data : 'z;

    assign rd_data   = rd_bank_q ? data2 : data1;
    assign out_valid = occ != 2'd0;
    assign out_data  = buf_data[rp];
    assign out_last  = buf_last[rp] && out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            addr        <= '0;
            wr_bank     <= 1'b0;
            rd_pend     <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_last_q   <= 1'b0;
            drain_all   <= 1'b0;
            drain_done  <= 1'b0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last    <= '0;
            occ         <= '0;
            wp          <= 1'b0;
            rp          <= 1'b0;
        end else begin
            rd_pend    <= rd;
            rd_bank_q  <= !wr_bank;
            rd_last_q  <= at_last;
            drain_done <= done;
            occ        <= occ + {1'b0, rd_pend} - {1'b0, pop};
            if (rd_pend) begin
                buf_data[wp] <= rd_data;
                buf_last[wp] <= rd_last_q;
                wp           <= !wp;
            end
            if (pop)
                rp <= !rp;
            if (state != DRAIN && wr) begin
                addr <= at_last ? '0 : addr + 1'b1;
                if (at_last) begin
                    wr_bank <= !wr_bank;
                    state   <= STREAM;
                end
            end else if (state == STREAM && addr == '0 && flush) begin
                state <= DRAIN;
            end else if (state == DRAIN) begin
                if (rd && at_last)
                    drain_all <= 1'b1;
                else if (rd)
                    addr <= addr + 1'b1;
                // Hand the drained bank back as the next write target.
                if (done) begin
                    state     <= FILL;
                    addr      <= '0;
                    wr_bank   <= !wr_bank;
                    drain_all <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pingpong_sram_ctrl.sv
// tb_pingpong_sram_ctrl: two behavioural SRAM banks, a frame-level reference
// model with an output scoreboard, directed vectors and random traffic.
module tb_pingpong_sram_ctrl;
    localparam int DW = 16, AW = 3, DEPTH = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, out_last, drain_done;
    logic [DW-1:0] out_data;
    logic [AW-1:0] addr;
    logic          cs1, cs2, we1, we2, oe1, oe2;
    wire  [DW-1:0] data1, data2;

    pingpong_sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .drain_done(drain_done), .addr(addr),
        .cs1(cs1), .cs2(cs2), .we1(we1), .we2(we2), .oe1(oe1), .oe2(oe2),
        .data1(data1), .data2(data2)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem1 [0:(1<<AW)-1];
    logic [DW-1:0] mem2 [0:(1<<AW)-1];
    logic [AW-1:0] ra1, ra2;
    always @(posedge clk) begin
        if (cs1 && we1) mem1[addr] <= data1;
        if (cs1 && !we1) ra1 <= addr;
        if (cs2 && we2) mem2[addr] <= data2;
        if (cs2 && !we2) ra2 <= addr;
    end
    assign data1 = oe1 ? mem1[ra1] : 'z;
    assign data2 = oe2 ? mem2[ra2] : 'z;

    int n_tot = 0, n_bad = 0, ndone = 0, npop = 0;
    logic [DW:0]   q[$];
    logic [DW-1:0] prev [DEPTH];
    logic [DW-1:0] cur  [DEPTH];
    int            idx = 0;
    bit            primed = 0, draining = 0;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a frame is a list of DEPTH words; a word accepted at index i of a
    // primed frame releases word i of the previous frame; a drain releases it whole.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete(); idx = 0; primed = 0; draining = 0;
                continue;
            end
            chk(!(we1 && oe1) && !(we2 && oe2) && !(we1 && we2) && int'(addr) < DEPTH &&
                !(we1 && data1 != in_data) && !(we2 && data2 != in_data),
                "bus", {20'b0, we1, oe1, we2, oe2, 5'b0, addr}, 32'h0);
            if (drain_done) begin
                chk(draining && q.size() == 0, "drain_done", q.size(), 0);
                draining = 0;
                ndone++;
            end
            if (!draining && primed && idx == 0 && flush) begin
                draining = 1;
                primed = 0;
                for (int i = 0; i < DEPTH; i++) q.push_back({i == DEPTH - 1, prev[i]});
            end
            if (draining) chk(!in_ready, "drain_rdy", in_ready, 0);
            if (in_valid && in_ready) begin
                cur[idx] = in_data;
                if (primed) q.push_back({idx == DEPTH - 1, prev[idx]});
                idx++;
                if (idx == DEPTH) begin
                    prev = cur; idx = 0; primed = 1;
                end
            end
            if (out_valid) begin
                if (q.size() == 0) chk(0, "spurious_out", {15'b0, out_last, out_data}, 0);
                else chk({out_last, out_data} == q[0], "out_word", {15'b0, out_last, out_data}, {15'b0, q[0]});
                if (out_ready && q.size() != 0) void'(q.pop_front());
                if (out_ready) npop++;
            end
        end
    endtask

    task automatic send(input logic [DW-1:0] d);
        int n = 0;
        in_valid = 1; in_data = d;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(in_ready, "send_timeout", n, 60);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 40 && ndone == d0; i++) @(negedge clk);
        chk(ndone == d0 + 1, "drain_pulse", ndone - d0, 1);
    endtask

    typedef struct {
        logic v; logic [DW-1:0] d; logic chk_rdy, e_rdy; logic [AW-1:0] e_addr;
        logic e_we1, e_we2, e_ov; logic [DW-1:0] e_od; logic e_ol;
    } vec_t;

    function automatic vec_t mk(logic v, logic [DW-1:0] d, logic cr, logic er, logic [AW-1:0] a,
                                logic w1, logic w2, logic ov, logic [DW-1:0] od, logic ol);
        vec_t t;
        t.v = v; t.d = d; t.chk_rdy = cr; t.e_rdy = er; t.e_addr = a;
        t.e_we1 = w1; t.e_we2 = w2; t.e_ov = ov; t.e_od = od; t.e_ol = ol;
        return t;
    endfunction

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        vec_t tbl [11];
        int d0, p0;
        tbl[0]  = mk(1, 16'h0001, 1, 1, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 16'h0002, 1, 1, 1, 1, 0, 0, 0, 0);
        tbl[2]  = mk(1, 16'h0003, 1, 1, 2, 1, 0, 0, 0, 0);
        tbl[3]  = mk(1, 16'h0004, 1, 1, 3, 1, 0, 0, 0, 0);
        tbl[4]  = mk(1, 16'h0011, 1, 1, 0, 0, 1, 0, 0, 0);
        tbl[5]  = mk(1, 16'h0012, 1, 1, 1, 0, 1, 0, 0, 0);
        tbl[6]  = mk(1, 16'h0013, 1, 1, 2, 0, 1, 1, 16'h0001, 0);
        tbl[7]  = mk(1, 16'h0014, 1, 1, 3, 0, 1, 1, 16'h0002, 0);
        tbl[8]  = mk(0, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0003, 0);
        tbl[9]  = mk(0, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0004, 1);
        tbl[10] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0);
        fork monitor(); join_none
        #12;
        chk(!out_valid && !out_last && out_data == 0 && !drain_done, "rst_out", {out_valid, out_last, out_data}, 0);
        chk(addr == 0, "rst_addr", addr, 0);
        chk({cs1, cs2, we1, we2, oe1, oe2} == 0, "rst_ctl", {cs1, cs2, we1, we2, oe1, oe2}, 0);
        @(posedge clk); #1;
        rst_n = 1; out_ready = 1;
        foreach (tbl[i]) begin
            in_valid = tbl[i].v; in_data = tbl[i].d;
            @(negedge clk);
            chk((!tbl[i].chk_rdy || in_ready == tbl[i].e_rdy) && addr == tbl[i].e_addr &&
                we1 == tbl[i].e_we1 && we2 == tbl[i].e_we2 && out_valid == tbl[i].e_ov &&
                (!tbl[i].e_ov || (out_data == tbl[i].e_od && out_last == tbl[i].e_ol)),
                $sformatf("vec%0d", i), {in_ready, addr, we1, we2, out_valid, out_last, out_data},
                {tbl[i].e_rdy, tbl[i].e_addr, tbl[i].e_we1, tbl[i].e_we2, tbl[i].e_ov, tbl[i].e_ol, tbl[i].e_od});
            @(posedge clk); #1;
        end
        // Frame 3 under backpressure with flush raised after its first word.
        p0 = npop; d0 = ndone;
        out_ready = 0; in_valid = 1; in_data = 16'h0021;
        @(negedge clk); chk(in_ready, "bp_first", in_ready, 1);
        @(posedge clk); #1;
        in_data = 16'h0022; flush = 1;
        @(negedge clk); chk(in_ready, "bp_second", in_ready, 1);
        @(posedge clk); #1;
        in_data = 16'h0023;
        repeat (3) begin
            @(negedge clk);
            chk(!in_ready && out_valid && out_data == 16'h0011, "bp_hold", {in_ready, out_valid, out_data}, {2'b01, 16'h0011});
            @(posedge clk); #1;
        end
        out_ready = 1;
        send(16'h0023);
        send(16'h0024);
        wait_done(d0);
        repeat (10) @(negedge clk);
        chk(ndone == d0 + 1, "no_retrigger", ndone - d0, 1);
        chk(npop == p0 + 8, "drain_count", npop - p0, 8);
        @(posedge clk); #1;
        flush = 0;
        // Frame 4 fills silently, frame 5 collides flush with its last accept.
        p0 = npop; d0 = ndone;
        for (int i = 0; i < 4; i++) send(16'h0031 + 16'(i));
        chk(npop == p0, "fill_silent", npop - p0, 0);
        for (int i = 0; i < 3; i++) send(16'h0041 + 16'(i));
        flush = 1;
        send(16'h0044);
        wait_done(d0);
        chk(npop == p0 + 8, "collide_count", npop - p0, 8);
        @(posedge clk); #1;
        flush = 0;
        // Asynchronous reset while the output buffer holds words.
        for (int i = 0; i < 4; i++) send(16'h0051 + 16'(i));
        out_ready = 0;
        send(16'h0061);
        send(16'h0062);
        #1;
        chk(out_valid, "pre_reset_valid", out_valid, 1);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk(!out_valid && !out_last && out_data == 0 && addr == 0, "arst_out", {out_valid, out_last, out_data}, 0);
        chk({cs1, cs2, we1, we2, oe1, oe2} == 0, "arst_ctl", {cs1, cs2, we1, we2, oe1, oe2}, 0);
        @(posedge clk); #1;
        rst_n = 1; out_ready = 1;
        p0 = npop;
        for (int i = 0; i < 4; i++) send(16'h0071 + 16'(i));
        repeat (4) @(posedge clk);
        #1;
        chk(npop == p0 && !out_valid, "post_reset_fill", npop - p0, 0);
        // Random traffic against the reference model.
        for (int c = 0; c < 800; c++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            in_data   = 16'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 15) == 0;
            @(posedge clk); #1;
        end
        in_valid = 0; flush = 0; out_ready = 1;
        repeat (30) @(posedge clk);
        #1;
        chk(q.size() == 0 && !draining, "quiesce", q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
